fpnew_divsqrt_dispatch: RTL

FPNEW_DIVSQRT_DISPATCH -- requirements
Module: fpnew_divsqrt_dispatch

---
 rtl/fpnew_divsqrt_dispatch.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fpnew_divsqrt_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_divsqrt_dispatch
// Purpose  : Issues divide/sqrt operations to a pool of iterative units and
//            retires their results through a single valid/ready port. The
//            issue order is kept in a small order FIFO. A result is returned
//            in issue order by default. With FPNEW_DIVSQRT_OOO_EN defined,
//            the lowest-index finished unit is returned first.
// Ports    : clk_i, rst_ni       - clock, synchronous active-low reset
//            in_valid_i/in_ready_o, is_div_i, tag_i - upstream operation
//            flush_i             - kill every operation in flight
//            unit_start_o        - one-hot start strobe to the chosen unit
//            unit_is_div_o, unit_kill_o - broadcasts to all units
//            unit_ready_i, unit_done_i, unit_result_i, unit_status_i
//                                - per-unit handshake and completion data
//            out_valid_o/out_ready_i, result_o, status_o, tag_o
//                                - downstream result handshake
//            busy_o              - any unit is BUSY or HOLD
// Config   : FPNEW_DIVSQRT_OOO_EN - out-of-order retirement
// Revision : 1.0 - initial release
// ============================================================================
module fpnew_divsqrt_dispatch #(
    parameter int unsigned NumUnits = 2,
    parameter int unsigned Width    = 64,
    parameter int unsigned TagWidth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic                           is_div_i,
    input  logic [TagWidth-1:0]            tag_i,
    input  logic                           flush_i,
    output logic [NumUnits-1:0]            unit_start_o,
    output logic                           unit_is_div_o,
    output logic                           unit_kill_o,
    input  logic [NumUnits-1:0]            unit_ready_i,
    input  logic [NumUnits-1:0]            unit_done_i,
    input  logic [NumUnits-1:0][Width-1:0] unit_result_i,
    input  logic [NumUnits-1:0][4:0]       unit_status_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [Width-1:0]               result_o,
    output logic [4:0]                     status_o,
    output logic [TagWidth-1:0]            tag_o,
    output logic                           busy_o
);

    localparam int unsigned c_IDX_W = (NumUnits > 1) ? $clog2(NumUnits) : 1;
    localparam int unsigned c_CNT_W = $clog2(NumUnits + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_BUSY = 2'd1;
    localparam state_t c_ST_HOLD = 2'd2;

    state_t              r_state    [NumUnits];
    state_t              w_state_nxt[NumUnits];
    logic [TagWidth-1:0] r_tag      [NumUnits];
    logic [Width-1:0]    r_result   [NumUnits];
    logic [4:0]          r_status   [NumUnits];

    // Order FIFO kept compacted: entry 0 is the oldest outstanding unit.
    logic [c_IDX_W-1:0]  r_fifo     [NumUnits];
    logic [c_IDX_W-1:0]  w_fifo_nxt [NumUnits];
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_nxt;

    logic [NumUnits-1:0] w_eligible;
    logic [NumUnits-1:0] w_hold;
    logic [c_IDX_W-1:0]  w_sel;
    logic                w_accept;
    logic [c_IDX_W-1:0]  w_ret_unit;
    logic [c_IDX_W-1:0]  w_ret_pos;
    logic                w_present;
    logic                w_retire;

    // ------------------------------------------------------------------
    // Issue side
    // ------------------------------------------------------------------
    always_comb begin
        w_eligible = '0;
        w_hold     = '0;
        busy_o     = 1'b0;
        for (int k = 0; k < NumUnits; k++) begin
            w_eligible[k] = (r_state[k] == c_ST_IDLE) && unit_ready_i[k];
            w_hold[k]     = (r_state[k] == c_ST_HOLD);
            if (r_state[k] != c_ST_IDLE) busy_o = 1'b1;
        end
    end

    // Lowest-index eligible unit wins: scan downwards so the lowest sticks.
    always_comb begin
        w_sel = '0;
        for (int k = int'(NumUnits) - 1; k >= 0; k--) begin
            if (w_eligible[k]) w_sel = c_IDX_W'(k);
        end
    end

    assign in_ready_o    = (|w_eligible) & ~flush_i & rst_ni;
    assign w_accept      = in_valid_i & in_ready_o;
    assign unit_is_div_o = is_div_i;
    assign unit_kill_o   = flush_i;

    always_comb begin
        unit_start_o = '0;
        if (w_accept) unit_start_o[w_sel] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Retire side: only registered HOLD state feeds out_valid_o, so a done
    // pulse is seen downstream one cycle later at the earliest.
    // ------------------------------------------------------------------
`ifdef FPNEW_DIVSQRT_OOO_EN
    always_comb begin
        w_ret_unit = '0;
        for (int k = int'(NumUnits) - 1; k >= 0; k--) begin
            if (w_hold[k]) w_ret_unit = c_IDX_W'(k);
        end
        // Locate the retiring unit inside the FIFO so its entry can be
        // squeezed out while the remaining order is preserved.
        w_ret_pos = '0;
        for (int i = int'(NumUnits) - 1; i >= 0; i--) begin
            if ((c_CNT_W'(i) < r_count) && (r_fifo[i] == w_ret_unit)) w_ret_pos = c_IDX_W'(i);
        end
        w_present = |w_hold;
    end
`else
    always_comb begin
        w_ret_unit = r_fifo[0];
        w_ret_pos  = '0;
        w_present  = (r_count != '0) && (r_state[r_fifo[0]] == c_ST_HOLD);
    end
`endif

    assign out_valid_o = w_present & ~flush_i & rst_ni;
    assign w_retire    = out_valid_o & out_ready_i;
    assign result_o    = r_result[w_ret_unit];
    assign status_o    = r_status[w_ret_unit];
    assign tag_o       = r_tag[w_ret_unit];

    // ------------------------------------------------------------------
    // Per-unit state machines
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NumUnits; k++) begin
            w_state_nxt[k] = r_state[k];
            case (r_state[k])
                c_ST_IDLE: if (w_accept && (w_sel == c_IDX_W'(k))) w_state_nxt[k] = c_ST_BUSY;
                c_ST_BUSY: if (unit_done_i[k]) w_state_nxt[k] = c_ST_HOLD;
                c_ST_HOLD: if (w_retire && (w_ret_unit == c_IDX_W'(k))) w_state_nxt[k] = c_ST_IDLE;
                default:   w_state_nxt[k] = c_ST_IDLE;
            endcase
            if (flush_i) w_state_nxt[k] = c_ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NumUnits; k++) begin
            if (!rst_ni) r_state[k] <= c_ST_IDLE;
            else         r_state[k] <= w_state_nxt[k];
        end
    end

    // ------------------------------------------------------------------
    // Order FIFO: pop (from any position) first, then append the new issue
    // behind the survivors.
    // ------------------------------------------------------------------
    always_comb begin
        w_fifo_nxt  = r_fifo;
        w_count_nxt = r_count;
        if (w_retire) begin
            for (int i = 0; i < int'(NumUnits) - 1; i++) begin
                if (c_IDX_W'(i) >= w_ret_pos) w_fifo_nxt[i] = r_fifo[i+1];
            end
            w_count_nxt = w_count_nxt - c_CNT_ONE;
        end
        if (w_accept) begin
            for (int i = 0; i < NumUnits; i++) begin
                if (c_CNT_W'(i) == w_count_nxt) w_fifo_nxt[i] = w_sel;
            end
            w_count_nxt = w_count_nxt + c_CNT_ONE;
        end
        if (flush_i) w_count_nxt = '0;
    end

    // ------------------------------------------------------------------
    // FIFO storage and per-unit capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_count <= '0;
            for (int k = 0; k < NumUnits; k++) begin
                r_fifo[k]   <= '0;
                r_tag[k]    <= '0;
                r_result[k] <= '0;
                r_status[k] <= '0;
            end
        end else begin
            r_count <= w_count_nxt;
            for (int k = 0; k < NumUnits; k++) begin
                r_fifo[k] <= w_fifo_nxt[k];
                if (w_accept && (w_sel == c_IDX_W'(k))) r_tag[k] <= tag_i;
                if ((r_state[k] == c_ST_BUSY) && unit_done_i[k]) begin
                    r_result[k] <= unit_result_i[k];
                    r_status[k] <= unit_status_i[k];
                end
            end
        end
    end

endmodule
`default_nettype wire
